// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: multiply/divide unit state
// and operation-kind encodings.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam logic MDU_OP_MULT = 1'b0;
  localparam logic MDU_OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit_core.sv
// Iterative shift/add (multiply) and restoring-subtract (divide) datapath.
// Works on unsigned magnitudes only; sign handling lives in the parent.
// Accumulator layout: upper half is the partial product / partial remainder,
// lower half is the multiplier / dividend that shifts into quotient bits.
module mdu_core
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 load_op,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mag_a,
  input  logic [WIDTH-1:0]     mag_b,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             op;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] acc_next;

  // One iteration of either algorithm, selected by the captured op kind
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    acc_next = acc;
    if (op == MDU_OP_MULT) begin
      // carry out of the add becomes the new MSB after the right shift
      if (acc[0]) acc_next = {sum, acc[WIDTH-1:1]};
      else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end else begin
      // diff[WIDTH] set means the trial subtraction borrowed: restore
      if (diff[WIDTH]) acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_next = {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};
    end
  end

  // Accumulator, operand and iteration counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op    <= MDU_OP_MULT;
      opnd  <= '0;
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      op    <= load_op;
      opnd  <= (load_op == MDU_OP_MULT) ? mag_a : mag_b;
      acc   <= {{WIDTH{1'b0}}, (load_op == MDU_OP_MULT) ? mag_b : mag_a};
      count <= CW'(WIDTH);
    end else if (step) begin
      acc   <= acc_next;
      count <= count - CW'(1);
    end
  end

  assign last = (count == CW'(1));

endmodule

// File: rtl/mult_div_unit.sv
// Shared iterative multiply/divide unit with signed/unsigned modes, a
// start/busy/done handshake and divide-by-zero flagging. Results are held in
// the Hi/Lo registers until the next completed operation or reset.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t         state;
  logic               op_kind;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               load;
  logic               load_op;
  logic               last;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // Operand magnitudes, start acceptance and sign-corrected results
  always_comb begin
    sa      = is_signed & op_a[WIDTH-1];
    sb      = is_signed & op_b[WIDTH-1];
    mag_a   = sa ? -op_a : op_a;
    mag_b   = sb ? -op_b : op_b;
    load    = (state == IDLE) && (start_mult || (start_div && (op_b != '0)));
    load_op = start_mult ? MDU_OP_MULT : MDU_OP_DIV;
    prod    = neg_q ? -acc : acc;
    quot    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_op (load_op),
    .step    (state == RUN),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .acc     (acc),
    .last    (last)
  );

  // Control FSM, result sign capture and Hi/Lo registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_kind <= MDU_OP_MULT;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_mult) begin
            op_kind <= MDU_OP_MULT;
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            dz      <= 1'b0;
            state   <= RUN;
          end else if (start_div) begin
            if (op_b == '0) begin
              dz    <= 1'b1;
              state <= DONE;
            end else begin
              op_kind <= MDU_OP_DIV;
              neg_q   <= sa ^ sb;
              neg_r   <= sa;
              dz      <= 1'b0;
              state   <= RUN;
            end
          end
        end
        RUN: if (last) state <= FIX;
        FIX: begin
          if (op_kind == MDU_OP_MULT) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end else begin
            hi <= rem;
            lo <= quot;
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == RUN) || (state == FIX);
  assign done     = (state == DONE);
  assign div_zero = (state == DONE) && dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a WIDTH=32 and a WIDTH=8 instance
// are checked every cycle against an arithmetic reference model, plus a set
// of hand-computed expectations.
module tb_mult_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, sm, sd, sg, busy, done, dzo;
  logic [31:0] a32, b32, hi32, lo32;
  logic [7:0]  a8, b8, hi8, lo8;

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst[0]), .start_mult(sm[0]), .start_div(sd[0]),
    .is_signed(sg[0]), .op_a(a32), .op_b(b32), .busy(busy[0]),
    .done(done[0]), .div_zero(dzo[0]), .hi(hi32), .lo(lo32)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst[1]), .start_mult(sm[1]), .start_div(sd[1]),
    .is_signed(sg[1]), .op_a(a8), .op_b(b8), .busy(busy[1]),
    .done(done[1]), .div_zero(dzo[1]), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wid(input int u);
    return (u == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] get_a(input int u);
    return (u == 0) ? a32 : {24'b0, a8};
  endfunction

  function automatic logic [31:0] get_b(input int u);
    return (u == 0) ? b32 : {24'b0, b8};
  endfunction

  function automatic logic [31:0] get_hi(input int u);
    return (u == 0) ? hi32 : {24'b0, hi8};
  endfunction

  function automatic logic [31:0] get_lo(input int u);
    return (u == 0) ? lo32 : {24'b0, lo8};
  endfunction

  // Reference arithmetic: interpret operands as w-bit values, compute the
  // exact product / truncating quotient and remainder, keep w-bit fields.
  function automatic void ref_op(input int w, input bit is_div, input bit s,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rhi, output logic [31:0] rlo);
    longint av, bv, p, q, r;
    logic [63:0] mask, pu;
    mask = (64'd1 << w) - 64'd1;
    av = longint'({32'b0, a} & mask);
    bv = longint'({32'b0, b} & mask);
    if (s && a[w-1]) av = av - (longint'(1) << w);
    if (s && b[w-1]) bv = bv - (longint'(1) << w);
    if (!is_div) begin
      p   = av * bv;
      pu  = p;
      rlo = 32'(pu & mask);
      rhi = 32'((pu >> w) & mask);
    end else begin
      q   = av / bv;
      r   = av % bv;
      pu  = q;
      rlo = 32'(pu & mask);
      pu  = r;
      rhi = 32'(pu & mask);
    end
  endfunction

  // Model state: k = cycles since the accepted start (0 when idle)
  int          k[2], lat[2];
  bit          mdz[2];
  logic [31:0] ehi[2], elo[2], phi[2], plo[2];

  // Reference model advances on each rising edge from the sampled inputs
  always @(posedge clk) begin : model
    logic [31:0] th, tl;
    for (int u = 0; u < 2; u++) begin
      if (rst[u]) begin
        k[u] <= 0; lat[u] <= 0; mdz[u] <= 1'b0; ehi[u] <= '0; elo[u] <= '0;
      end else if (k[u] == 0) begin
        if (sm[u] || sd[u]) begin
          k[u] <= 1;
          if (!sm[u] && get_b(u) == 32'd0) begin
            mdz[u] <= 1'b1; lat[u] <= 1;
          end else begin
            ref_op(wid(u), !sm[u], sg[u], get_a(u), get_b(u), th, tl);
            phi[u] <= th; plo[u] <= tl; mdz[u] <= 1'b0; lat[u] <= wid(u) + 2;
          end
        end
      end else if (k[u] == lat[u]) begin
        k[u] <= 0;
      end else begin
        k[u] <= k[u] + 1;
        if (k[u] + 1 == lat[u] && !mdz[u]) begin
          ehi[u] <= phi[u]; elo[u] <= plo[u];
        end
      end
    end
  end

  // Compare every DUT output against the model on every cycle
  always @(negedge clk) begin
    if (armed) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("busy[u%0d]", u), {31'b0, busy[u]}, {31'b0, (k[u] > 0 && k[u] < lat[u])});
        chk($sformatf("done[u%0d]", u), {31'b0, done[u]}, {31'b0, (k[u] > 0 && k[u] == lat[u])});
        chk($sformatf("div_zero[u%0d]", u), {31'b0, dzo[u]},
            {31'b0, (k[u] > 0 && k[u] == lat[u] && mdz[u])});
        chk($sformatf("hi[u%0d]", u), get_hi(u), ehi[u]);
        chk($sformatf("lo[u%0d]", u), get_lo(u), elo[u]);
      end
    end
  end

  function automatic logic [31:0] rnd_val(input int w);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'd1 << (w - 1);
      2:       return mask;
      3:       return 32'($urandom % 8);
      default: return $urandom & mask;
    endcase
  endfunction

  // Issue one operation and wait (bounded) for done; lat_o is the cycle of done
  task automatic run_op(input int u, input bit mult, input bit both, input bit s,
                        input logic [31:0] a, input logic [31:0] b,
                        input int mid_div, output int lat_o);
    @(negedge clk);
    sm[u] = mult; sd[u] = !mult || both; sg[u] = s;
    if (u == 0) begin a32 = a; b32 = b; end else begin a8 = a[7:0]; b8 = b[7:0]; end
    @(negedge clk);
    sm[u] = 1'b0; sd[u] = 1'b0;
    // operands are don't-care after capture: scramble them
    if (u == 0) begin a32 = $urandom; b32 = $urandom; end else begin a8 = 8'($urandom); b8 = 8'($urandom); end
    sg[u] = 1'($urandom);
    lat_o = -1;
    for (int c = 1; c <= 100; c++) begin
      sd[u] = (c == mid_div);
      if (done[u]) begin lat_o = c; break; end
      @(negedge clk);
    end
    sd[u] = 1'b0;
    if (lat_o < 0) chk($sformatf("done_seen[u%0d]", u), {31'b0, done[u]}, 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lt;
    rst = 2'b11; sm = '0; sd = '0; sg = '0;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    @(posedge clk);
    armed = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_hi32", hi32, 32'd0);
    chk("reset_lo32", lo32, 32'd0);
    chk("reset_busy", {30'b0, busy}, 32'd0);
    rst = 2'b00;

    // Hand-computed WIDTH=32 cases
    run_op(0, 1, 0, 1, 32'd7, 32'hFFFF_FFFD, 0, lt);
    chk("smul_lat", lt, 34);
    chk("smul_hi", hi32, 32'hFFFF_FFFF);
    chk("smul_lo", lo32, 32'hFFFF_FFEB);
    run_op(0, 0, 0, 1, 32'd9, 32'd0, 0, lt);
    chk("div0_lat", lt, 1);
    chk("div0_flag", {31'b0, dzo[0]}, 32'd1);
    chk("div0_hi", hi32, 32'hFFFF_FFFF);
    chk("div0_lo", lo32, 32'hFFFF_FFEB);
    run_op(0, 1, 0, 0, 32'hFFFF_FFFF, 32'd2, 0, lt);
    chk("umul_hi", hi32, 32'h0000_0001);
    chk("umul_lo", lo32, 32'hFFFF_FFFE);
    run_op(0, 0, 0, 1, 32'hFFFF_FFF9, 32'd2, 0, lt);
    chk("sdiv_lat", lt, 34);
    chk("sdiv_lo", lo32, 32'hFFFF_FFFD);
    chk("sdiv_hi", hi32, 32'hFFFF_FFFF);
    run_op(0, 0, 0, 0, 32'hFFFF_FFF9, 32'd2, 0, lt);
    chk("udiv_lo", lo32, 32'h7FFF_FFFC);
    chk("udiv_hi", hi32, 32'h0000_0001);
    run_op(0, 0, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lt);
    chk("ovf_lo", lo32, 32'h8000_0000);
    chk("ovf_hi", hi32, 32'h0000_0000);
    chk("ovf_dz", {31'b0, dzo[0]}, 32'd0);

    // WIDTH=8 handshake: latency, ignored mid-op start_div
    run_op(1, 1, 0, 1, 32'h0000_00F9, 32'd3, 4, lt);
    chk("w8_lat", lt, 10);
    chk("w8_hi", {24'b0, hi8}, 32'h0000_00FF);
    chk("w8_lo", {24'b0, lo8}, 32'h0000_00EB);

    // Start sampled in the DONE cycle is ignored
    sm[1] = 1'b1; a8 = 8'd5; b8 = 8'd5;
    @(negedge clk);
    sm[1] = 1'b0;
    chk("done_restart_busy", {31'b0, busy[1]}, 32'd0);

    // Reset during RUN cycle 4, then an immediate new start
    @(negedge clk);
    sm[1] = 1'b1; sg[1] = 1'b0; a8 = 8'd12; b8 = 8'd11;
    @(negedge clk);
    sm[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("rst_busy", {31'b0, busy[1]}, 32'd0);
    chk("rst_done", {31'b0, done[1]}, 32'd0);
    chk("rst_hi", {24'b0, hi8}, 32'd0);
    chk("rst_lo", {24'b0, lo8}, 32'd0);
    sm[1] = 1'b1; sg[1] = 1'b0; a8 = 8'd12; b8 = 8'd11;
    @(negedge clk);
    sm[1] = 1'b0;
    lt = -1;
    for (int c = 1; c <= 100; c++) begin
      if (done[1]) begin lt = c; break; end
      @(negedge clk);
    end
    chk("post_rst_lat", lt, 10);
    chk("post_rst_lo", {24'b0, lo8}, 32'd132);

    // Randomised traffic on both widths
    for (int i = 0; i < 30; i++)
      run_op(0, 1'($urandom), 1'b0, 1'($urandom), rnd_val(32), rnd_val(32), 0, lt);
    for (int i = 0; i < 80; i++)
      run_op(1, 1'($urandom), 1'($urandom), 1'($urandom), rnd_val(8), rnd_val(8),
             int'($urandom % 12), lt);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
